// File: rtl/alu_mc.sv
// Multi-cycle RV32I ALU with valid/ready handshake; shifts iterate one bit per cycle.
// Define ALU_MC_MUL_EN to build the iterative shift-add multiplier for opcode 1010.
module alu_mc #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_zero,
   output logic             out_illegal
);
   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [3:0]       op;
   logic [WIDTH-1:0] acc;
   logic [SHW:0]     cnt;
   logic [WIDTH-1:0] res;
   logic             res_ill;
   logic [WIDTH-1:0] nxt;
   logic             is_shift;
`ifdef ALU_MC_MUL_EN
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
`endif

   assign is_shift = (ctrl == 4'b0101) || (ctrl == 4'b0110) || (ctrl == 4'b0111);

   // Single-cycle results; a shift by zero simply passes a through.
   always_comb begin
      res     = '0;
      res_ill = 1'b0;
      case (ctrl)
         4'b0000: res = a + b;
         4'b0001: res = a - b;
         4'b0010: res = a & b;
         4'b0011: res = a | b;
         4'b0100: res = a ^ b;
         4'b0101,
         4'b0110,
         4'b0111: res = a;
         4'b1000: res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
         4'b1001: res = (a < b) ? WIDTH'(1) : '0;
`ifdef ALU_MC_MUL_EN
         4'b1010: res = '0;
`endif
         default: res_ill = 1'b1;
      endcase
   end

   always_comb begin
      nxt = acc;
      case (op)
         4'b0101: nxt = {acc[WIDTH-2:0], 1'b0};
         4'b0110: nxt = {1'b0, acc[WIDTH-1:1]};
         4'b0111: nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
`ifdef ALU_MC_MUL_EN
         4'b1010: nxt = mplier[0] ? acc + mcand : acc;
`endif
         default: nxt = acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out         <= '0;
         out_zero    <= 1'b0;
         out_illegal <= 1'b0;
         op          <= '0;
         acc         <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op <= ctrl;
                  if (is_shift && (b[SHW-1:0] != '0)) begin
                     acc      <= a;
                     cnt      <= {1'b0, b[SHW-1:0]};
                     in_ready <= 1'b0;
                     state    <= BUSY;
                  end
`ifdef ALU_MC_MUL_EN
                  else if (ctrl == 4'b1010) begin
                     acc      <= '0;
                     mcand    <= a;
                     mplier   <= b;
                     cnt      <= (SHW+1)'(WIDTH);
                     in_ready <= 1'b0;
                     state    <= BUSY;
                  end
`endif
                  else begin
                     out         <= res;
                     out_zero    <= (res == '0);
                     out_illegal <= res_ill;
                     out_valid   <= 1'b1;
                     in_ready    <= 1'b0;
                     state       <= DONE;
                  end
               end
            end
            BUSY: begin
               acc <= nxt;
               cnt <= cnt - 1'b1;
`ifdef ALU_MC_MUL_EN
               mcand  <= {mcand[WIDTH-2:0], 1'b0};
               mplier <= {1'b0, mplier[WIDTH-1:1]};
`endif
               // Final iteration writes the result straight out, so no extra cycle is spent.
               if (cnt == (SHW+1)'(1)) begin
                  out         <= nxt;
                  out_zero    <= (nxt == '0);
                  out_illegal <= 1'b0;
                  out_valid   <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus randomized ops against an arithmetic reference model.
module tb_alu_mc;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   ctrl;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out;
   logic         out_zero;
   logic         out_illegal;

   int tests = 0;
   int fails = 0;

   alu_mc #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ctrl(ctrl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .out_zero(out_zero), .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic ill, output int lat);
      int sh;
      sh  = int'(y % W);
      r   = '0;
      ill = 1'b0;
      lat = 1;
      case (c)
         4'd0: r = x + y;
         4'd1: r = x - y;
         4'd2: r = x & y;
         4'd3: r = x | y;
         4'd4: r = x ^ y;
         4'd5: begin r = x << sh; lat = sh + 1; end
         4'd6: begin r = x >> sh; lat = sh + 1; end
         4'd7: begin r = W'($signed(x) >>> sh); lat = sh + 1; end
         4'd8: r = ($signed(x) < $signed(y)) ? 1 : 0;
         4'd9: r = (x < y) ? 1 : 0;
`ifdef ALU_MC_MUL_EN
         4'd10: begin r = x * y; lat = W + 1; end
`endif
         default: ill = 1'b1;
      endcase
   endfunction

   // Issue one op, measure latency (edges from accept inclusive), hold backpressure, then release.
   task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold, input bit keep_valid);
      logic [W-1:0] er;
      logic         eill;
      int           elat;
      int           lat;
      int           guard;
      model(c, x, y, er, eill, elat);
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_before_issue", 64'(in_ready), 64'(1));
      in_valid = 1'b1;
      ctrl     = c;
      a        = x;
      b        = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ctrl     = 4'($urandom);
      a        = $urandom;
      b        = $urandom;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check($sformatf("latency op%0d", c), 64'(lat), 64'(elat));
      check($sformatf("out op%0d", c), 64'(out), 64'(er));
      check($sformatf("zero op%0d", c), 64'(out_zero), 64'(er == '0));
      check($sformatf("illegal op%0d", c), 64'(out_illegal), 64'(eill));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_out", 64'(out), 64'(er));
         check("hold_in_ready", 64'(in_ready), 64'(0));
      end
      out_ready = 1'b1;
      if (keep_valid) begin
         in_valid = 1'b1;
         ctrl     = 4'd0;
         a        = 1;
         b        = 1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("release_valid", 64'(out_valid), 64'(0));
      check("release_in_ready", 64'(in_ready), 64'(1));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      ctrl      = 4'd0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out", 64'(out), 64'(0));
      check("rst_zero", 64'(out_zero), 64'(0));
      check("rst_illegal", 64'(out_illegal), 64'(0));
      in_valid = 1'b0;
      rst_n    = 1'b1;

      run_op(4'b0000, 5, 4, 0, 1'b0);
      run_op(4'b0001, 13, 13, 0, 1'b0);
      run_op(4'b1000, -32'sd77, 36, 0, 1'b0);
      run_op(4'b1001, -32'sd77, 36, 0, 1'b0);
      run_op(4'b0111, -32'sd400, 16, 0, 1'b0);
      run_op(4'b0101, 1, 32'h26, 0, 1'b0);
      run_op(4'b0110, -32'sd5132, 0, 0, 1'b0);
      run_op(4'b0010, 749, 619, 5, 1'b1);
      run_op(4'b1010, 65035, -32'sd3, 0, 1'b0);
      run_op(4'b1111, 7, 9, 0, 1'b0);
      run_op(4'b0101, 32'h8000_0001, 31, 1, 1'b0);

      // Reset during a shift must abort it without producing a result.
      @(negedge clk);
      in_valid = 1'b1;
      ctrl     = 4'b0110;
      a        = 32'hFFFF_0000;
      b        = 20;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("abort_busy", 64'(in_ready), 64'(0));
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_out_valid", 64'(out_valid), 64'(0));
      check("abort_in_ready", 64'(in_ready), 64'(1));
      rst_n = 1'b1;
      run_op(4'b0011, 1, 2, 0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         run_op(4'($urandom_range(15)), $urandom, $urandom, $urandom_range(2), 1'($urandom_range(1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, multi-cycle successor to the combinational 3-bit-opcode ALU, for the RV32I datapath.
- Widens the opcode to 4 bits and adds SLT/SLTU, plus an optional iterative multiplier.
- Shifts are iterative (one bit per cycle), so the block needs no barrel shifter.
- Valid/ready handshake on both sides; sits between decode/issue and writeback.

Parameters:
WIDTH, 32, operand/result width in bits (power of 2, >= 8)
SHW, $clog2(WIDTH), shift-amount width (derived localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/opcode valid
in_ready  output  1  block can accept an operation
ctrl  input  4  opcode
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
out_zero  output  1  out == 0
out_illegal  output  1  opcode not supported

Behaviour:
- Reset: sampled on the rising clk edge while rst_n=0 (synchronous, active-low). Forces state=IDLE, in_ready=1, out_valid=0, out=0, out_zero=0, out_illegal=0. Reset mid-operation aborts it; no result is produced.
- States:
  - IDLE: in_ready=1. Accept when in_valid&&in_ready at a clk edge; latch a, b, ctrl.
  - BUSY: iterating; in_ready=0.
  - DONE: out_valid=1, in_ready=0. Leave to IDLE at the edge where out_ready=1.
- Opcodes:
  - 0000 a+b
  - 0001 a-b
  - 0010 a&b
  - 0011 a|b
  - 0100 a^b
  - 0101 a<<sh
  - 0110 a>>sh (logical)
  - 0111 a>>>sh (arithmetic)
  - 1000 slt: signed a<b ? 1 : 0
  - 1001 sltu: unsigned a<b ? 1 : 0
  - 1010 mul: low WIDTH bits of a*b (optional feature)
  - others: illegal
- Shift amount: sh = b[SHW-1:0]; upper bits of b are ignored.
- Arithmetic: all results modulo 2^WIDTH; no carry or overflow output.
- Latency, counted from the accept edge to the edge where out_valid rises:
  - Logic/arith/slt/illegal: IDLE->DONE directly, 1 cycle.
  - Shifts: IDLE->BUSY, one bit per cycle, total sh+1 cycles. sh=0 goes IDLE->DONE, 1 cycle.
  - mul: shift-add, one multiplier bit per cycle, exactly WIDTH+1 cycles regardless of operand values.
- Illegal opcode: out=0, out_illegal=1, 1-cycle latency.
- out_zero and out_illegal are valid only while out_valid=1 and are registered with out.
- Output stability: out, out_zero and out_illegal are held stable while out_valid && !out_ready.
- Back-to-back: no accept in the DONE cycle, even if out_ready=1. The next accept occurs at the earliest one cycle later, in IDLE. Max throughput is one op per 2 cycles.
- Inputs a, b and ctrl are ignored outside the accept edge; changes during BUSY have no effect.
- in_valid may drop without an accept; nothing is latched.

Optional Feature:
Macro ALU_MC_MUL_EN.
- Defined: opcode 1010 runs the iterative multiplier as above, with latency WIDTH+1.
- Undefined: no multiplier logic is built. 1010 is treated as illegal (out=0, out_illegal=1, 1-cycle latency).

Test Plan:
- Reset with rst_n=0 held over 2 edges while in_valid=1 -> in_ready=1, out_valid=0, out=0. Release, send ctrl=0000, a=5, b=4 -> out=9 one cycle after accept, out_zero=0.
- ctrl=0001, a=13, b=13 -> out=0, out_zero=1. ctrl=1000, a=-77, b=36 -> out=1. ctrl=1001 with the same operands -> out=0.
- Shifts with WIDTH=32:
  - ctrl=0111, a=-400, b=16 -> out=-1 (0xFFFFFFFF), out_valid 17 cycles after accept.
  - ctrl=0101, a=1, b=0x26 (sh=6) -> out=64, 7 cycles.
  - ctrl=0110, a=-5132, b=0 -> out=0xFFFFEBF4, 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with a=749, b=619, ctrl=0010 -> out=0x269 stays stable and in_ready=0. Then raise out_ready for 1 cycle -> next op is accepted no earlier than the following edge.
- Multiply: ctrl=1010, a=65035, b=-3:
  - With ALU_MC_MUL_EN -> out=-195105 after 33 cycles.
  - Without it -> out=0, out_illegal=1 after 1 cycle.
  - ctrl=1111 in either build -> out_illegal=1.
- Abort: drive rst_n=0 mid-shift (ctrl=0110, b=20, 5 cycles into BUSY) -> next edge returns IDLE with out_valid=0. A new op (ctrl=0011, a=1, b=2) then returns out=3 normally.
